// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared Rijndael datapath constants, types and helpers
package aes_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        SR_FWD = 1'b0,
        SR_INV = 1'b1
    } sr_mode_e;

    // Row rotation amount; the 256-bit block skips offset 2 for rows 2 and 3.
    function automatic int shift_offset(input int nb, input int r);
        if (nb == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rijndael_row_perm.sv
// rtl/rijndael_row_perm.sv - combinational ShiftRows/InvShiftRows byte permutation
module rijndael_row_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] in_data,
    input  sr_mode_e         inv,
    output logic [32*NB-1:0] out_data
);

    localparam int DW = 32*NB;

    // Byte k = 4c + r sits at the MSB end, so every index is counted down from DW-1.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int S    = shift_offset(NB, r);
            localparam int FC   = (c + S) % NB;
            localparam int IC   = (c - S + NB) % NB;
            localparam int DST  = DW - 1 - BYTE_W*(4*c + r);
            localparam int FSRC = DW - 1 - BYTE_W*(4*FC + r);
            localparam int ISRC = DW - 1 - BYTE_W*(4*IC + r);

            assign out_data[DST -: BYTE_W] = (inv == SR_INV) ? in_data[ISRC -: BYTE_W]
                                                             : in_data[FSRC -: BYTE_W];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - registered ShiftRows stage with a 2-entry elastic buffer
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_inv,
    input  logic [32*NB-1:0]    in_data,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*NB-1:0]    out_data,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int DW = 32*NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    logic [DW-1:0]    perm_data;
    logic [DW-1:0]    buf_data [2];
    logic [TAG_W-1:0] buf_tag  [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    rijndael_row_perm #(.NB(NB)) u_perm (
        .in_data  (in_data),
        .inv      (sr_mode_e'(in_inv)),
        .out_data (perm_data)
    );

    // Handshake flags decode registered state only, so ready never depends on valid.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_data  = buf_data[rd_ptr];
    assign out_tag   = buf_tag[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_tag[0]  <= '0;
            buf_tag[1]  <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= perm_data;
                buf_tag[wr_ptr]  <= in_tag;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb/tb_shift_rows_pipe.sv - scoreboard bench for shift_rows_pipe at NB = 4, 6 and 8
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // NB = 4 instance
    logic         n4_in_valid, n4_in_ready, n4_in_inv, n4_out_valid, n4_out_ready;
    logic [127:0] n4_in_data, n4_out_data;
    logic [3:0]   n4_in_tag, n4_out_tag;
    // NB = 6 instance
    logic         n6_in_valid, n6_in_ready, n6_in_inv, n6_out_valid, n6_out_ready;
    logic [191:0] n6_in_data, n6_out_data;
    logic [3:0]   n6_in_tag, n6_out_tag;
    // NB = 8 instance
    logic         n8_in_valid, n8_in_ready, n8_in_inv, n8_out_valid, n8_out_ready;
    logic [255:0] n8_in_data, n8_out_data;
    logic [3:0]   n8_in_tag, n8_out_tag;

    shift_rows_pipe #(.NB(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n4_in_valid), .in_ready(n4_in_ready), .in_inv(n4_in_inv),
        .in_data(n4_in_data), .in_tag(n4_in_tag),
        .out_valid(n4_out_valid), .out_ready(n4_out_ready),
        .out_data(n4_out_data), .out_tag(n4_out_tag)
    );

    shift_rows_pipe #(.NB(6), .TAG_W(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n6_in_valid), .in_ready(n6_in_ready), .in_inv(n6_in_inv),
        .in_data(n6_in_data), .in_tag(n6_in_tag),
        .out_valid(n6_out_valid), .out_ready(n6_out_ready),
        .out_data(n6_out_data), .out_tag(n6_out_tag)
    );

    shift_rows_pipe #(.NB(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n8_in_valid), .in_ready(n8_in_ready), .in_inv(n8_in_inv),
        .in_data(n8_in_data), .in_tag(n8_in_tag),
        .out_valid(n8_out_valid), .out_ready(n8_out_ready),
        .out_data(n8_out_data), .out_tag(n8_out_tag)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference permutation on a right-aligned 32*nb-bit block.
    function automatic logic [255:0] perm_model(input int nb, input logic inv, input logic [255:0] x);
        logic [255:0] y;
        int w, s, src;
        y = '0;
        w = 32*nb;
        for (int r = 0; r < 4; r++) begin
            s = r;
            if (nb == 8 && r > 1) s = r + 1;
            for (int c = 0; c < nb; c++) begin
                if (inv) src = (c + nb - s) % nb;
                else     src = (c + s) % nb;
                y[w-1-8*(4*c+r) -: 8] = x[w-1-8*(4*src+r) -: 8];
            end
        end
        return y;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    logic [131:0] q4 [$];
    logic [255:0] q6 [$];
    logic [255:0] q8 [$];
    logic [255:0] cap6 [$];
    logic [255:0] cap8 [$];
    int           pops4 = 0;
    bit           mon4_en = 1'b1;

    always @(negedge clk) begin
        logic [255:0] e;
        logic [131:0] x;
        if (mon4_en) begin
            if (n4_in_valid && n4_in_ready) begin
                e = perm_model(4, n4_in_inv, {128'b0, n4_in_data});
                q4.push_back({n4_in_tag, e[127:0]});
            end
            if (n4_out_valid && n4_out_ready) begin
                if (q4.size() == 0) begin
                    check("sb4_extra_block", 1, 0);
                end else begin
                    x = q4.pop_front();
                    check("sb4_data", n4_out_data, x[127:0]);
                    check("sb4_tag", n4_out_tag, x[131:128]);
                end
                pops4++;
            end
        end
    end

    always @(negedge clk) begin
        logic [255:0] e;
        if (n6_out_valid && n6_out_ready) begin
            if (q6.size() == 0) check("sb6_extra_block", 1, 0);
            else begin
                e = q6.pop_front();
                check("sb6_data", {64'b0, n6_out_data}, e);
            end
            cap6.push_back({64'b0, n6_out_data});
        end
        if (n8_out_valid && n8_out_ready) begin
            if (q8.size() == 0) check("sb8_extra_block", 1, 0);
            else begin
                e = q8.pop_front();
                check("sb8_data", n8_out_data, e);
            end
            cap8.push_back(n8_out_data);
        end
    end

    // Offer one block to the NB=6/8 instance; called and returns at posedge+1.
    task automatic send_w(input int nb, input logic inv, input logic [255:0] d, input logic [255:0] e);
        bit got;
        int t;
        got = 0;
        t = 0;
        if (nb == 6) begin
            n6_in_valid = 1; n6_in_inv = inv; n6_in_data = d[191:0];
        end else begin
            n8_in_valid = 1; n8_in_inv = inv; n8_in_data = d;
        end
        while (!got && t < 50) begin
            @(negedge clk);
            if (nb == 6 && n6_in_ready) begin got = 1; q6.push_back(e); end
            if (nb == 8 && n8_in_ready) begin got = 1; q8.push_back(e); end
            @(posedge clk); #1;
            t++;
        end
        n6_in_valid = 0;
        n8_in_valid = 0;
        if (!got) check("send_timeout", 0, 1);
    endtask

    task automatic drain(input int nb);
        int sz;
        for (int t = 0; t < 30; t++) begin
            sz = (nb == 4) ? q4.size() : (nb == 6) ? q6.size() : q8.size();
            if (sz == 0) break;
            @(posedge clk); #1;
        end
        sz = (nb == 4) ? q4.size() : (nb == 6) ? q6.size() : q8.size();
        check("drain_empty", sz, 0);
    endtask

    task automatic run_roundtrip(input int nb);
        logic [255:0] orig [$];
        logic [255:0] fwd  [$];
        logic [255:0] d;
        if (nb == 6) cap6.delete(); else cap8.delete();
        for (int i = 0; i < 1000; i++) begin
            d = rand256();
            if (nb == 6) d[255:192] = '0;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            orig.push_back(d);
            send_w(nb, 1'b0, d, perm_model(nb, 1'b0, d));
        end
        drain(nb);
        fwd = (nb == 6) ? cap6 : cap8;
        check("rt_fwd_count", fwd.size(), 1000);
        for (int i = 0; i < fwd.size() && i < 1000; i++) begin
            send_w(nb, 1'b1, fwd[i], orig[i]);
        end
        drain(nb);
    endtask

    initial begin
        int acc, p0, blk;
        logic [255:0] d;

        rst_n = 0;
        n4_in_valid = 0; n4_in_inv = 0; n4_in_data = '0; n4_in_tag = '0; n4_out_ready = 0;
        n6_in_valid = 0; n6_in_inv = 0; n6_in_data = '0; n6_in_tag = '0; n6_out_ready = 1;
        n8_in_valid = 0; n8_in_inv = 0; n8_in_data = '0; n8_in_tag = '0; n8_out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", n4_in_ready, 1);
        check("rst_out_valid", n4_out_valid, 0);
        check("rst_out_data", n4_out_data, 0);
        check("rst_out_tag", n4_out_tag, 0);
        rst_n = 1;

        // Known-answer vectors, forward then inverse
        @(posedge clk); #1;
        n4_in_valid = 1; n4_in_data = 128'h000102030405060708090a0b0c0d0e0f;
        n4_in_tag = 4'h5; n4_in_inv = 0; n4_out_ready = 1;
        @(negedge clk);
        check("fwd_no_bypass", n4_out_valid, 0);
        @(posedge clk); #1;
        n4_in_valid = 0;
        @(negedge clk);
        check("fwd_valid", n4_out_valid, 1);
        check("fwd_kat", n4_out_data, 128'h00050a0f04090e03080d02070c01060b);
        check("fwd_tag", n4_out_tag, 4'h5);
        @(posedge clk); #1;
        n4_in_valid = 1; n4_in_tag = 4'ha; n4_in_inv = 1;
        @(posedge clk); #1;
        n4_in_valid = 0;
        @(negedge clk);
        check("inv_kat", n4_out_data, 128'h000d0a0704010e0b0805020f0c090603);
        check("inv_tag", n4_out_tag, 4'ha);
        @(posedge clk); #1;

        // Backpressure: four cycles offered, only two fit
        n4_out_ready = 0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            n4_in_valid = 1; n4_in_data = rand256(); n4_in_tag = 4'(i + 1); n4_in_inv = i[0];
            @(negedge clk);
            if (n4_in_ready) acc++;
            @(posedge clk); #1;
        end
        n4_in_valid = 0;
        check("bp_accepted", acc, 2);
        @(negedge clk);
        check("bp_in_ready_low", n4_in_ready, 0);
        check("bp_out_valid", n4_out_valid, 1);
        p0 = pops4;
        @(posedge clk); #1;
        n4_out_ready = 1;
        @(negedge clk);
        check("bp_ready_before_pop", n4_in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_ready_after_pop", n4_in_ready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_empty", n4_out_valid, 0);
        check("bp_pop_count", pops4 - p0, 2);
        @(posedge clk); #1;

        // Random handshakes, direction alternating per accepted block
        blk = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            n4_in_valid = ($urandom_range(0, 3) != 0);
            n4_out_ready = ($urandom_range(0, 2) != 0);
            n4_in_data = rand256();
            n4_in_tag = 4'($urandom);
            n4_in_inv = blk[0];
            @(negedge clk);
            if (n4_in_valid && n4_in_ready) blk++;
            @(posedge clk); #1;
        end
        n4_in_valid = 0;
        n4_out_ready = 1;
        drain(4);

        // Full duty cycle: one block per cycle
        acc = 0;
        p0 = pops4;
        for (int cyc = 0; cyc < 20; cyc++) begin
            n4_in_valid = 1; n4_in_data = rand256(); n4_in_tag = 4'(cyc); n4_in_inv = cyc[0];
            @(negedge clk);
            if (n4_in_ready) acc++;
            @(posedge clk); #1;
        end
        n4_in_valid = 0;
        check("full_rate_accepts", acc, 20);
        check("full_rate_pops", pops4 - p0, 19);
        drain(4);

        // Asynchronous reset with the buffer full
        n4_out_ready = 0;
        n4_in_valid = 1; n4_in_data = rand256(); n4_in_tag = 4'h3;
        @(posedge clk); #1;
        n4_in_data = rand256(); n4_in_tag = 4'h4;
        @(posedge clk); #1;
        n4_in_valid = 0;
        @(negedge clk);
        check("rst_full_before", n4_in_ready, 0);
        #2;
        mon4_en = 0;
        q4.delete();
        rst_n = 0;
        #1;
        check("arst_out_valid", n4_out_valid, 0);
        check("arst_out_data", n4_out_data, 0);
        check("arst_out_tag", n4_out_tag, 0);
        check("arst_in_ready", n4_in_ready, 1);
        @(posedge clk); #3;
        rst_n = 1;
        mon4_en = 1;
        @(posedge clk); #1;
        n4_out_ready = 1;
        n4_in_valid = 1; n4_in_data = 128'h000102030405060708090a0b0c0d0e0f;
        n4_in_tag = 4'h9; n4_in_inv = 0;
        @(negedge clk);
        check("post_rst_no_stale", n4_out_valid, 0);
        @(posedge clk); #1;
        n4_in_valid = 0;
        @(negedge clk);
        check("post_rst_valid", n4_out_valid, 1);
        check("post_rst_data", n4_out_data, 128'h00050a0f04090e03080d02070c01060b);
        check("post_rst_tag", n4_out_tag, 4'h9);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_single", n4_out_valid, 0);
        @(posedge clk); #1;

        // NB=8 offsets: byte k = k
        for (int k = 0; k < 32; k++) d[255-8*k -: 8] = 8'(k);
        send_w(8, 1'b0, d, perm_model(8, 1'b0, d));
        @(negedge clk);
        check("nb8_row1_col1", n8_out_data[247 -: 8], 8'h05);
        check("nb8_row3_col4", n8_out_data[231 -: 8], 8'h13);
        @(posedge clk); #1;
        drain(8);

        run_roundtrip(6);
        run_roundtrip(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
# shift_rows_pipe

Parametrised, registered ShiftRows/InvShiftRows stage for the Rijndael datapath. It supports block widths of 128, 192 and 256 bits (NB = 4, 6 or 8 columns). The direction is selected per transaction. A 2-entry elastic buffer with valid/ready handshakes on both sides lets it sit between the SubBytes and MixColumns stages of a pipelined round without combinational ready paths.

## Interface
- NB, default 4: state columns; legal values 4, 6, 8; any other value is an elaboration error.
- TAG_W, default 4: width of the sideband tag carried unchanged with each block.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream block present.
- in_ready  output  1  block accepted on this edge when in_valid & in_ready.
- in_inv  input  1  0 = forward ShiftRows, 1 = InvShiftRows; sampled with the block.
- in_data  input  32*NB  state, byte k at bits [32*NB-1-8k -: 8], k = 4c + r (column-major, row r, column c).
- in_tag  input  TAG_W  sideband, passed through.
- out_valid  output  1  out_data/out_tag hold a block.
- out_ready  input  1  downstream accepts when out_valid & out_ready.
- out_data  output  32*NB  permuted state, same byte layout.
- out_tag  output  TAG_W  tag of the block on out_data.

## Operation
- Row offsets s(r): NB=4 and NB=6 use 0,1,2,3; NB=8 uses 0,1,3,4.
- Forward: out[r][c] = in[r][(c + s(r)) mod NB].
- Inverse: out[r][c] = in[r][(c − s(r)) mod NB], with non-negative modulo.
- The permutation is applied combinationally on the input side. The permuted data plus the tag is written into the buffer; the in_inv bit is not stored.
- Buffer: 2 entries, with a write pointer, a read pointer and a 2-bit count (0..2).
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - out_data and out_tag come from the head entry.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
  - Count update: count ± 1; unchanged on simultaneous push and pop.
- Count = 2 with out_ready high: the pop happens and no push happens that cycle. in_ready rises the next cycle.
- Count = 0: a push only; out_valid rises next cycle. There is no combinational bypass.
- Pointers are 1 bit wide and wrap 1 → 0.
- Block order is strictly FIFO. in_inv may differ block to block with no bubble.
- Reset (asynchronous, any time, including with entries pending):
  - count = 0, pointers = 0, all entries = 0.
  - Outputs: in_ready = 1, out_valid = 0, out_data = 0, out_tag = 0.
  - Pending blocks are discarded.
- in_data is ignored while in_valid is low. Data on the input is not required to be stable across stalls.

## Timing
- Latency: 1 cycle. A block accepted at edge t is visible at out_* after edge t, provided the buffer was empty.
- Throughput: 1 block per cycle while out_ready stays high.
- in_ready and out_valid are pure register decodes with no combinational dependence on in_valid or out_ready.
- out_data and out_tag stay stable while out_valid & !out_ready.
- After out_ready has been low with count = 2, in_ready returns to 1 one cycle after the first pop.

## Structure
- Shared package aes_pkg:
  - function shift_offset(nb, r) returning s(r);
  - constant BYTE_W = 8;
  - typedef for the mode bit (SR_FWD, SR_INV).
- Sub-module rijndael_row_perm: purely combinational, parameter NB, inputs data and inv, output data.
  - Built from a generate loop over r, c using shift_offset.
  - Reusable by the key-schedule and debug paths.
- shift_rows_pipe contains the permutation instance, the 2-entry buffer and the handshake logic.

## Test plan
- NB=4, forward, in_data = 000102030405060708090a0b0c0d0e0f, out_ready = 1 → one cycle later out_data = 00050a0f04090e03080d02070c01060b, with out_tag equal to the input tag.
- NB=4, inverse, same input → out_data = 000d0a0704010e0b0805020f0c090603.
- NB=6 and NB=8: 1000 random blocks sent forward, with the outputs fed back inverse.
  - Every block must come back identical.
  - NB=8: input byte k = k must produce byte 1 from column 1 and byte 3 from column 4 of row 3.
- Backpressure: out_ready = 0 and in_valid = 1 for 4 cycles.
  - Exactly 2 blocks are accepted, then in_ready = 0.
  - Release out_ready → the 2 blocks emerge in order, in_ready = 1 one cycle after the first pop, and nothing is lost or duplicated.
- Streaming with randomised in_valid/out_ready and alternating in_inv: a scoreboard checks order, data and tags; at 100% duty cycle there is 1 block per cycle.
- Assert rst_n low asynchronously mid-cycle with count = 2.
  - Outputs go to zero immediately and in_ready = 1.
  - After release, the first new block appears with 1-cycle latency and no stale data.
